// File: rtl/lane_delay_pkg.sv
// Purpose : shared mode encodings and tap-selection helper for the lane delay buffer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: MODE_* encodings of the 2-bit mode field; tap_sel() maps (mode, lane) to the
//           stage index whose contents drive that lane's output.
package lane_delay_pkg;

   localparam logic [1:0] MODE_UNIFORM = 2'd0;
   localparam logic [1:0] MODE_SKEW    = 2'd1;
   localparam logic [1:0] MODE_DESKEW  = 2'd2;

   // Stage index = delay - 1. The reserved encoding (3) falls into the default
   // branch and therefore behaves as UNIFORM.
   function automatic int tap_sel(input logic [1:0] mode, input int k,
                                  input int lanes, input int depth);
      case (mode)
         MODE_SKEW:   return k;
         MODE_DESKEW: return lanes - 1 - k;
         default:     return depth - 1;
      endcase
   endfunction

endpackage

// File: rtl/delay_lane.sv
// Purpose : one lane of the delay buffer - a DEPTH-stage shift chain carrying {valid, data}.
// Latency : output is stage[tap], i.e. tap+1 en-asserted edges after the word was captured.
// Backpressure: en=0 freezes every stage; clear zeroes every stage and wins over en.
// Ports   : clk, reset_n (async, active-low), en, clear, din/din_valid (lane input),
//           tap (stage index to present), dout/dout_valid (tapped stage), any_valid (any stage valid).
module delay_lane #(
   parameter int DW    = 20,
   parameter int DEPTH = 16,
   parameter int TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          clear,
   input  logic [DW-1:0] din,
   input  logic          din_valid,
   input  logic [TW-1:0] tap,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          any_valid
);

   // Bit DW of each stage is the valid flag; bits DW-1:0 are the data word.
   logic [DW:0] stage [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (en) begin
         stage[0] <= {din_valid, din};
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout       = stage[tap][DW-1:0];
   assign dout_valid = stage[tap][DW];

   // Valid words keep travelling past the tap until they fall off the end, so the
   // whole chain is inspected, not just the tapped stage.
   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i][DW];
   end

endmodule

// File: rtl/lane_delay_buffer.sv
// Purpose : LANES independent delay lanes with mode-selected taps (uniform / skew / deskew).
// Latency : lane k delay D(k) en-edges: UNIFORM = DEPTH, SKEW = k+1, DESKEW = LANES-k.
// Backpressure: none; en=0 stalls all lanes in place, clear flushes them.
// Ports   : clk, reset_n, en, clear, mode (requested), din/din_valid (lane k at [k*DW +: DW]),
//           dout/dout_valid (tapped), busy (any valid anywhere), mode_active (applied mode).
module lane_delay_buffer
   import lane_delay_pkg::*;
#(
   parameter int LANES = 16,
   parameter int DW    = 20,
   parameter int DEPTH = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic                clear,
   input  logic [1:0]          mode,
   input  logic [LANES*DW-1:0] din,
   input  logic [LANES-1:0]    din_valid,
   output logic [LANES*DW-1:0] dout,
   output logic [LANES-1:0]    dout_valid,
   output logic                busy,
   output logic [1:0]          mode_active
);

   localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < LANES) begin : g_depth_check
      $error("lane_delay_buffer: DEPTH (%0d) must be >= LANES (%0d)", DEPTH, LANES);
   end

   logic [1:0]       mode_q;
   logic [LANES-1:0] lane_busy;

   // Taps may only move when nothing is in flight, otherwise a word would be
   // emitted twice or skipped. clear empties the pipe, so it also permits a change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q <= MODE_UNIFORM;
      end else if (clear || !busy) begin
         mode_q <= mode;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [TW-1:0] tap;

      always_comb tap = TW'(tap_sel(mode_q, k, LANES, DEPTH));

      delay_lane #(
         .DW    (DW),
         .DEPTH (DEPTH),
         .TW    (TW)
      ) u_lane (
         .clk        (clk),
         .reset_n    (reset_n),
         .en         (en),
         .clear      (clear),
         .din        (din[k*DW +: DW]),
         .din_valid  (din_valid[k]),
         .tap        (tap),
         .dout       (dout[k*DW +: DW]),
         .dout_valid (dout_valid[k]),
         .any_valid  (lane_busy[k])
      );
   end

   assign busy        = |lane_busy;
   assign mode_active = mode_q;

endmodule

// File: tb/tb_lane_delay_buffer.sv
module tb_lane_delay_buffer;

   localparam int LANES = 16;
   localparam int DW    = 20;
   localparam int DEPTH = 16;
   localparam int W     = LANES * DW;

   typedef struct {
      int            lane;
      logic [DW-1:0] data;
      int            due;
   } ent_t;

   logic             clk;
   logic             reset_n;
   logic             en;
   logic             clear;
   logic [1:0]       mode;
   logic [1:0]       mode_b;
   logic [W-1:0]     din;
   logic [LANES-1:0] din_valid;

   logic [W-1:0]     dout_a;
   logic [LANES-1:0] dv_a;
   logic             busy_a;
   logic [1:0]       mode_a;
   logic [W-1:0]     dout_b;
   logic [LANES-1:0] dv_b;
   logic             busy_b;
   logic [1:0]       mode_b_act;

   int total = 0;
   int bad   = 0;

   ent_t sb[$];
   int   en_cnt    = 0;
   int   wall      = 0;
   int   last_push = 0;
   bit   pushed    = 0;
   logic [1:0] mode_exp = 2'd0;

   lane_delay_buffer #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) u_a (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .clear       (clear),
      .mode        (mode),
      .din         (din),
      .din_valid   (din_valid),
      .dout        (dout_a),
      .dout_valid  (dv_a),
      .busy        (busy_a),
      .mode_active (mode_a)
   );

   // Second instance fed by the first: SKEW into DESKEW.
   lane_delay_buffer #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) u_b (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .clear       (clear),
      .mode        (mode_b),
      .din         (dout_a),
      .din_valid   (dv_a),
      .dout        (dout_b),
      .dout_valid  (dv_b),
      .busy        (busy_b),
      .mode_active (mode_b_act)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int dly(input logic [1:0] m, input int k);
      case (m)
         2'd1:    return k + 1;
         2'd2:    return LANES - k;
         default: return DEPTH;
      endcase
   endfunction

   // A valid word occupies some stage for DEPTH en-edges after capture.
   function automatic logic busy_exp();
      return pushed && (en_cnt <= last_push + DEPTH - 1);
   endfunction

   task automatic load(input logic [LANES-1:0] v, input int base, input bit rnd);
      for (int k = 0; k < LANES; k++)
         din[k*DW +: DW] = rnd ? DW'($urandom) : DW'(base + k);
      din_valid = v;
   endtask

   task automatic check_outputs();
      logic [LANES-1:0] ev;
      logic [W-1:0]     ed;
      logic [W-1:0]     mask;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].due < en_cnt) sb.delete(i);
      ev = '0; ed = '0; mask = '0;
      foreach (sb[i]) begin
         if (sb[i].due == en_cnt) begin
            ev[sb[i].lane]              = 1'b1;
            ed[sb[i].lane*DW +: DW]     = sb[i].data;
            mask[sb[i].lane*DW +: DW]   = '1;
         end
      end
      chk("dout_valid", W'(dv_a), W'(ev));
      chk("dout", dout_a & mask, ed);
      chk("busy", W'(busy_a), W'(busy_exp()));
      chk("mode_active", W'(mode_a), W'(mode_exp));
   endtask

   // One clock: update the expectation model from the inputs seen at the edge,
   // then sample the DUT 1 time unit later.
   task automatic tick();
      logic pre_busy;
      pre_busy = busy_exp();
      @(posedge clk);
      wall++;
      if (clear) begin
         sb.delete();
         pushed   = 0;
         mode_exp = mode;
      end else begin
         if (!pre_busy) mode_exp = mode;
         if (en) begin
            en_cnt++;
            if (din_valid != '0) begin
               for (int k = 0; k < LANES; k++) begin
                  if (din_valid[k]) begin
                     ent_t e;
                     e.lane = k;
                     e.data = din[k*DW +: DW];
                     e.due  = en_cnt + dly(mode_exp, k) - 1;
                     sb.push_back(e);
                  end
               end
               pushed    = 1;
               last_push = en_cnt;
            end
         end
      end
      #1;
      check_outputs();
   endtask

   initial begin : stim
      int p;
      int w0;
      logic [W-1:0] exp_b;

      reset_n = 1'b0; en = 1'b0; clear = 1'b0; mode = 2'd0; mode_b = 2'd2;
      din = '0; din_valid = '0;

      // Reset state
      #2;
      chk("rst_dout", dout_a, '0);
      chk("rst_dout_valid", W'(dv_a), '0);
      chk("rst_busy", W'(busy_a), '0);
      chk("rst_mode", W'(mode_a), '0);
      @(negedge clk);
      reset_n = 1'b1;

      // UNIFORM: lane k = k+1, visible after 16 en-edges
      en = 1'b1;
      load('1, 1, 0);
      tick();
      load('0, 0, 1);
      repeat (17) tick();

      // Reserved mode 3 behaves as UNIFORM, reported as 3
      mode = 2'd3;
      load('1, 'h50, 0);
      tick();
      chk("mode3_active", W'(mode_a), W'(2'd3));
      din_valid = '0;
      repeat (17) tick();

      // Let the chained instance drain
      repeat (20) tick();

      // SKEW: mode change and first word on the same edge; chained DESKEW aligns all lanes
      mode = 2'd1;
      load('1, 'h100, 0);
      tick();
      p = en_cnt;
      din_valid = '0;
      chk("b_mode", W'(mode_b_act), W'(2'd2));
      for (int k = 0; k < LANES; k++) exp_b[k*DW +: DW] = DW'('h100 + k);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("b_dout_valid", W'(dv_b), (en_cnt == p + LANES) ? W'({LANES{1'b1}}) : '0);
         if (en_cnt == p + LANES) chk("b_dout", dout_b, exp_b);
      end

      // Stall mid-flight: lane 0 word appears after 16 en-edges, 21 wall cycles
      mode = 2'd0;
      load('0, 0, 1);
      din[0 +: DW] = 20'hABCDE;
      din_valid = 16'h0001;
      tick();
      w0 = wall;
      din_valid = '0;
      repeat (7) tick();
      en = 1'b0;
      load('1, 0, 1);            // must not be captured while stalled
      repeat (5) tick();
      din_valid = '0;
      en = 1'b1;
      repeat (8) tick();
      chk("stall_wall", W'(wall - w0 + 1), W'(21));
      chk("stall_word", W'(dout_a[0 +: DW]), W'(20'hABCDE));
      en = 1'b0;
      repeat (2) tick();         // output must hold while stalled
      en = 1'b1;
      repeat (17) tick();

      // Clear wins over en: 8 words in flight, none ever emerges
      for (int i = 0; i < 8; i++) begin
         load('1, 0, 1);
         tick();
      end
      load('1, 0, 1);
      clear = 1'b1;
      tick();
      chk("clear_dout", dout_a, '0);
      clear = 1'b0;
      din_valid = '0;
      repeat (20) tick();

      // Deferred mode change while busy
      mode = 2'd0;
      load('1, 'h200, 0);
      tick();
      din_valid = '0;
      mode = 2'd2;
      repeat (15) tick();
      chk("defer_hold", W'(mode_a), W'(2'd0));
      repeat (3) tick();
      chk("defer_apply", W'(mode_a), W'(2'd2));
      load('1, 'h300, 0);
      tick();
      din_valid = '0;
      repeat (3) tick();
      mode = 2'd1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_mode", W'(mode_a), W'(2'd1));
      repeat (18) tick();

      // Async reset mid-stream under DESKEW
      mode = 2'd2;
      load('1, 'h400, 0);
      tick();
      tick();
      din_valid = '0;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_dout", dout_a, '0);
      chk("arst_dout_valid", W'(dv_a), '0);
      chk("arst_busy", W'(busy_a), '0);
      chk("arst_mode", W'(mode_a), '0);
      sb.delete();
      pushed   = 0;
      mode_exp = 2'd0;
      mode     = 2'd0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      load('1, 'h500, 0);
      tick();
      din_valid = '0;
      repeat (17) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
